// File: rtl/reg_file_pkg.sv
// Shared constants and types for the multi-port register file.
package reg_file_pkg;
   localparam int DEF_DATA_W   = 32;
   localparam int DEF_NUM_REGS = 32;
   localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);
   localparam int ZERO_REG     = 0;

   typedef logic [DEF_DATA_W-1:0] word_t;
   typedef logic [DEF_ADDR_W-1:0] reg_idx_t;
endpackage

// File: rtl/reg_file_wr_sel.sv
// Priority selector: folds NUM_WR write ports into per-register enable and data.
// The highest-index port targeting a register wins; register 0 never gets an enable.
module reg_file_wr_sel
   import reg_file_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int NUM_WR   = 2,
   parameter int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic [NUM_WR-1:0]                   wr_en,
   input  logic [NUM_WR*ADDR_W-1:0]            wr_addr,
   input  logic [NUM_WR*DATA_W-1:0]            wr_data,
   output logic [NUM_REGS-1:0]                 reg_we,
   output logic [NUM_REGS-1:0][DATA_W-1:0]     reg_wd
);

   always_comb begin
      reg_we = '0;
      reg_wd = '0;
      for (int r = ZERO_REG + 1; r < NUM_REGS; r++) begin
         // Ascending scan lets later (higher-index) ports overwrite earlier ones.
         for (int k = 0; k < NUM_WR; k++) begin
            if (wr_en[k] && (wr_addr[k*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
               reg_we[r] = 1'b1;
               reg_wd[r] = wr_data[k*DATA_W +: DATA_W];
            end
         end
      end
   end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with per-register pending scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter  int DATA_W   = DEF_DATA_W,
   parameter  int NUM_REGS = DEF_NUM_REGS,
   parameter  int NUM_RD   = 2,
   parameter  int NUM_WR   = 2,
   localparam int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   output logic [NUM_RD-1:0]          rd_pend,
   input  logic [NUM_WR-1:0]          wr_en,
   input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
   input  logic [NUM_WR*DATA_W-1:0]   wr_data,
   input  logic                       iss_en,
   input  logic [ADDR_W-1:0]          iss_addr,
   output logic                       any_pend
);

   logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
   logic [NUM_REGS-1:0]             pend_q, pend_d;
   logic [NUM_REGS-1:0]             reg_we;
   logic [NUM_REGS-1:0][DATA_W-1:0] reg_wd;
   logic [ADDR_W-1:0]               ra;

   reg_file_wr_sel #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .NUM_WR   (NUM_WR),
      .ADDR_W   (ADDR_W)
   ) u_wr_sel (
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .reg_we  (reg_we),
      .reg_wd  (reg_wd)
   );

   // Issue sets after writeback clears, so a new producer stays outstanding.
   always_comb begin
      regs_d = regs_q;
      pend_d = pend_q;
      for (int r = 0; r < NUM_REGS; r++) begin
         if (reg_we[r]) begin
            regs_d[r] = reg_wd[r];
            pend_d[r] = 1'b0;
         end
         if (iss_en && (iss_addr == ADDR_W'(r))) begin
            pend_d[r] = 1'b1;
         end
      end
      regs_d[ZERO_REG] = '0;
      pend_d[ZERO_REG] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         regs_q <= '0;
         pend_q <= '0;
      end else begin
         regs_q <= regs_d;
         pend_q <= pend_d;
      end
   end

   always_comb begin
      rd_data = '0;
      rd_pend = '0;
      ra      = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         ra = rd_addr[i*ADDR_W +: ADDR_W];
         rd_data[i*DATA_W +: DATA_W] = regs_q[ra];
         rd_pend[i]                  = pend_q[ra];
`ifdef REGFILE_BYPASS_EN
         // Gated by reset so outputs read zero while reset is held.
         if (reset && reg_we[ra]) begin
            rd_data[i*DATA_W +: DATA_W] = reg_wd[ra];
            rd_pend[i] = (iss_en && (iss_addr == ra)) ? pend_q[ra] : 1'b0;
         end
`endif
      end
   end

   assign any_pend = |pend_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomised scoreboard bench for reg_file_mp (2R/2W/32 and 4R/1W/16 builds).
module tb_reg_file_mp;
   import reg_file_pkg::*;

   logic         clk = 1'b0;
   logic         reset;

   // Main instance: 32 regs, 2 read ports, 2 write ports
   logic [9:0]   rd_addr;
   logic [63:0]  rd_data;
   logic [1:0]   rd_pend;
   logic [1:0]   wr_en;
   logic [9:0]   wr_addr;
   logic [63:0]  wr_data;
   logic         iss_en;
   logic [4:0]   iss_addr;
   logic         any_pend;

   // Second instance: 16 regs, 4 read ports, 1 write port
   logic [15:0]  rd_addr4;
   logic [127:0] rd_data4;
   logic [3:0]   rd_pend4;
   logic [0:0]   wr_en4;
   logic [3:0]   wr_addr4;
   logic [31:0]  wr_data4;
   logic         iss_en4;
   logic [3:0]   iss_addr4;
   logic         any_pend4;

   reg_file_mp u_dut (
      .clk      (clk),
      .reset    (reset),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_pend  (rd_pend),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .any_pend (any_pend)
   );

   reg_file_mp #(.DATA_W(32), .NUM_REGS(16), .NUM_RD(4), .NUM_WR(1)) u_dut4 (
      .clk      (clk),
      .reset    (reset),
      .rd_addr  (rd_addr4),
      .rd_data  (rd_data4),
      .rd_pend  (rd_pend4),
      .wr_en    (wr_en4),
      .wr_addr  (wr_addr4),
      .wr_data  (wr_data4),
      .iss_en   (iss_en4),
      .iss_addr (iss_addr4),
      .any_pend (any_pend4)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   word_t        m_mem  [32];
   bit           m_pend [32];
   word_t        m4_mem [16];

   logic [1:0]   cur_we;
   int           cur_wa [2];
   word_t        cur_wd [2];
   logic         cur_iss;
   int           cur_ia;
   logic         cur_we4;
   int           cur_wa4;
   word_t        cur_wd4;

   // ---------------- scoreboard ----------------
   logic [31:0]  exp_q [$];
   int           kind_q [$];
   int           checks   = 0;
   int           failures = 0;

   function automatic string kname(input int k);
      case (k)
         0: return "rd_data0";
         1: return "rd_data1";
         2: return "rd_pend0";
         3: return "rd_pend1";
         4: return "any_pend";
         5: return "dut4_rd_data0";
         6: return "dut4_rd_data1";
         7: return "dut4_rd_data2";
         default: return "dut4_rd_data3";
      endcase
   endfunction

   function automatic logic [31:0] actual(input int k);
      case (k)
         0: return rd_data[31:0];
         1: return rd_data[63:32];
         2: return {31'b0, rd_pend[0]};
         3: return {31'b0, rd_pend[1]};
         4: return {31'b0, any_pend};
         5: return rd_data4[31:0];
         6: return rd_data4[63:32];
         7: return rd_data4[95:64];
         default: return rd_data4[127:96];
      endcase
   endfunction

   function automatic void clear_model();
      for (int r = 0; r < 32; r++) begin
         m_mem[r]  = '0;
         m_pend[r] = 1'b0;
      end
      for (int r = 0; r < 16; r++) m4_mem[r] = '0;
   endfunction

   // Expected read of the main instance given the inputs currently driven.
   function automatic void exp_rd(input int a, output word_t d, output logic p);
      d = m_mem[a];
      p = m_pend[a];
`ifdef REGFILE_BYPASS_EN
      if (a != 0) begin
         for (int k = 0; k < 2; k++) begin
            if (cur_we[k] && cur_wa[k] == a) begin
               d = cur_wd[k];
               p = (cur_iss && cur_ia == a) ? m_pend[a] : 1'b0;
            end
         end
      end
`endif
   endfunction

   function automatic word_t exp_rd4(input int a);
      word_t d;
      d = m4_mem[a];
`ifdef REGFILE_BYPASS_EN
      if (a != 0 && cur_we4 && cur_wa4 == a) d = cur_wd4;
`endif
      return d;
   endfunction

   function automatic void push(input int k, input logic [31:0] v);
      kind_q.push_back(k);
      exp_q.push_back(v);
   endfunction

   // Monitor: compares every queued expectation at the falling edge.
   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         automatic logic [31:0] e = exp_q.pop_front();
         automatic int          k = kind_q.pop_front();
         automatic logic [31:0] a = actual(k);
         checks++;
         if (a !== e) begin
            failures++;
            $display("FAIL %s t=%0t got=%h expected=%h", kname(k), $time, a, e);
         end
      end
   end

   // ---------------- driver ----------------
   // Called just after a rising edge; drives one cycle, queues expectations,
   // then advances the model across the next rising edge.
   task automatic step(input logic [1:0] we, input int a0, input word_t d0,
                       input int a1, input word_t d1, input logic iss,
                       input int ia, input int r0, input int r1);
      word_t d;
      logic  p;
      int    base;
      cur_we = we; cur_wa[0] = a0; cur_wa[1] = a1; cur_wd[0] = d0; cur_wd[1] = d1;
      cur_iss = iss; cur_ia = ia;
      wr_en    = we;
      wr_addr  = {5'(a1), 5'(a0)};
      wr_data  = {d1, d0};
      iss_en   = iss;
      iss_addr = 5'(ia);
      rd_addr  = {5'(r1), 5'(r0)};

      cur_we4  = 1'($urandom_range(0, 1));
      cur_wa4  = $urandom_range(0, 15);
      cur_wd4  = $urandom;
      base     = $urandom_range(0, 15);
      wr_en4   = cur_we4;
      wr_addr4 = 4'(cur_wa4);
      wr_data4 = cur_wd4;
      for (int j = 0; j < 4; j++) rd_addr4[j*4 +: 4] = 4'((base + j) % 16);

      exp_rd(r0, d, p); push(0, d); push(2, {31'b0, p});
      exp_rd(r1, d, p); push(1, d); push(3, {31'b0, p});
      begin
         automatic logic ap = 1'b0;
         for (int r = 0; r < 32; r++) ap |= m_pend[r];
         push(4, {31'b0, ap});
      end
      for (int j = 0; j < 4; j++) push(5 + j, exp_rd4((base + j) % 16));

      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         if (cur_we[k] && cur_wa[k] != 0) begin
            m_mem[cur_wa[k]]  = cur_wd[k];
            m_pend[cur_wa[k]] = 1'b0;
         end
      end
      if (cur_iss && cur_ia != 0) m_pend[cur_ia] = 1'b1;
      if (cur_we4 && cur_wa4 != 0) m4_mem[cur_wa4] = cur_wd4;
   endtask

   // Asserts reset between edges with a write in flight; outputs must clear at once.
   task automatic reset_mid();
      wr_en   = 2'b01;
      wr_addr = {5'd0, 5'd5};
      wr_data = {32'h0, 32'h5555};
      iss_en  = 1'b0;
      rd_addr = {5'd5, 5'd5};
      wr_en4  = 1'b1;
      wr_addr4 = 4'd5;
      wr_data4 = 32'h5555;
      rd_addr4 = {4'd5, 4'd4, 4'd3, 4'd5};
      #1;
      reset = 1'b0;
      clear_model();
      for (int k = 0; k < 9; k++) push(k, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      wr_en = '0; wr_addr = '0; wr_data = '0; iss_en = 1'b0; iss_addr = '0; rd_addr = '0;
      wr_en4 = '0; wr_addr4 = '0; wr_data4 = '0; iss_en4 = 1'b0; iss_addr4 = '0;
      rd_addr4 = 16'h3210;
      clear_model();
      @(posedge clk);
      #1;
      rd_addr = {5'd1, 5'd31};
      for (int k = 0; k < 9; k++) push(k, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Basic write/read and r0 hardwiring
      step(2'b01, 3, 32'hDEADBEEF, 0, 0, 1'b0, 0, 3, 0);
      step(2'b01, 0, 32'h0000FFFF, 0, 0, 1'b0, 0, 3, 0);
      step(2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 3);
      // Both ports to r7: higher index wins
      step(2'b11, 7, 32'h11, 7, 32'h22, 1'b0, 0, 7, 0);
      step(2'b00, 0, 0, 0, 0, 1'b0, 0, 7, 7);
      // Scoreboard set/clear and set-wins collision
      step(2'b00, 0, 0, 0, 0, 1'b1, 9, 9, 0);
      step(2'b00, 0, 0, 0, 0, 1'b0, 0, 9, 9);
      step(2'b01, 9, 32'h09090909, 0, 0, 1'b0, 0, 9, 0);
      step(2'b00, 0, 0, 0, 0, 1'b0, 0, 9, 0);
      step(2'b10, 0, 0, 9, 32'h99, 1'b1, 9, 9, 0);
      step(2'b00, 0, 0, 0, 0, 1'b0, 0, 9, 9);
      step(2'b00, 0, 0, 0, 0, 1'b1, 0, 0, 9);
      // Same-cycle write and read of r4
      step(2'b01, 4, 32'hCAFE, 0, 0, 1'b0, 0, 4, 4);
      step(2'b00, 0, 0, 0, 0, 1'b0, 0, 4, 9);

      // Random traffic; reads often aimed at write/issue targets
      for (int n = 0; n < 400; n++) begin
         automatic int a0 = $urandom_range(0, 31);
         automatic int a1 = ($urandom_range(0, 3) == 0) ? a0 : $urandom_range(0, 31);
         automatic int ia = $urandom_range(0, 31);
         automatic int r0 = ($urandom_range(0, 2) == 0) ? a0 : $urandom_range(0, 31);
         automatic int r1 = ($urandom_range(0, 2) == 0) ? ia : $urandom_range(0, 31);
         step(2'($urandom_range(0, 3)), a0, $urandom, a1, $urandom,
              1'($urandom_range(0, 2) == 0), ia, r0, r1);
      end

      // Reset mid-run after r5 written and pending
      step(2'b01, 5, 32'h1234, 0, 0, 1'b1, 5, 0, 0);
      step(2'b00, 0, 0, 0, 0, 1'b0, 0, 5, 5);
      reset_mid();
      step(2'b00, 0, 0, 0, 0, 1'b0, 0, 5, 0);
      for (int n = 0; n < 40; n++) begin
         step(2'($urandom_range(0, 3)), $urandom_range(0, 31), $urandom,
              $urandom_range(0, 31), $urandom, 1'($urandom_range(0, 1)),
              $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
      end

      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain left=%0d expected=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL timeout t=%0t limit=200000", $time);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
